// File: rtl/pwm_rom_sequencer.sv
// pwm_rom_sequencer
//   Reader side of the switching-state ROM. Issues ROM reads at a programmable
//   sample rate (one read every div+1 clocks), walks the table 0..LAST_ADDR
//   with wrap-around, absorbs the ROM's 1-cycle registered read latency and
//   presents the three 4-bit switching words as aligned gate commands.
//
// Ports
//   clk          clock, shared with the ROM
//   rst          synchronous active-high reset
//   start        level; leaves IDLE and starts reading at address 0
//   stop         level; halts reads, lets an in-flight read finish, then
//                clears the gate commands (stop beats start in IDLE)
//   div          sample divider, picked up on every prescaler reload
//   rom_en       ROM read enable (registered)
//   rom_addr     ROM read address (registered)
//   rom_out1..3  ROM data, valid one cycle after rom_en
//   sw1..sw3     registered switching words, phases 1..3
//   sw_valid     one-cycle pulse when sw1..3 update
//   period_tick  pulses with the sw_valid of the LAST_ADDR sample
//   busy         high in RUN and DRAIN
module pwm_rom_sequencer #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = '1,
  parameter int unsigned       DIV_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_out1,
  input  logic [3:0]        rom_out2,
  input  logic [3:0]        rom_out3,
  output logic [3:0]        sw1,
  output logic [3:0]        sw2,
  output logic [3:0]        sw3,
  output logic              sw_valid,
  output logic              period_tick,
  output logic              busy
);

  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  presc, presc_nx;
  logic [DIV_W-1:0]  div_q, div_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              issue;
  logic              to_idle;

  // Read tracking: [0] is the read being presented to the ROM (rom_en),
  // [1] is the read whose data is on rom_out*, [2] is the sw_valid pulse.
  // last_pipe shadows it with a "this read was LAST_ADDR" flag.
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] last_pipe;

  assign rom_en      = vld_pipe[0];
  assign sw_valid    = vld_pipe[STAGES];
  assign period_tick = last_pipe[STAGES];
  assign busy        = (state != IDLE);
  assign to_idle     = (state != IDLE) && (state_nx == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state. A read is still outstanding at a stop if it is on the ROM
  // port now (rom_en) or its data is being captured at this edge
  // (vld_pipe[1]); DRAIN holds until no capture remains so the final
  // sw_valid is shown before the words are cleared.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && !stop) state_nx = RUN;
      RUN:     if (stop) state_nx = (rom_en || vld_pipe[1]) ? DRAIN : IDLE;
      DRAIN:   if (!vld_pipe[1]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read issue / prescaler / address next values. rom_addr holds the most
  // recently issued address; the next issue uses its successor.
  always_comb begin
    issue    = 1'b0;
    addr_nx  = rom_addr;
    presc_nx = presc;
    div_nx   = div_q;
    unique case (state)
      IDLE: begin
        addr_nx = '0;
        if (state_nx == RUN) begin
          issue    = 1'b1;
          presc_nx = '0;
          div_nx   = div;
        end
      end
      RUN: begin
        if (!stop) begin
          if (presc == div_q) begin
            issue    = 1'b1;
            presc_nx = '0;
            div_nx   = div;
            addr_nx  = (rom_addr == LAST_ADDR) ? '0 : rom_addr + 1'b1;
          end else begin
            presc_nx = presc + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (to_idle) addr_nx = '0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      presc     <= '0;
      div_q     <= '0;
      rom_addr  <= '0;
      sw1       <= '0;
      sw2       <= '0;
      sw3       <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], issue};
      last_pipe <= {last_pipe[STAGES-1:0], issue && (addr_nx == LAST_ADDR)};
      presc     <= presc_nx;
      div_q     <= div_nx;
      rom_addr  <= addr_nx;
      // Never both in one cycle: IDLE is only entered once no capture remains.
      if (vld_pipe[1]) begin
        sw1 <= rom_out1;
        sw2 <= rom_out2;
        sw3 <= rom_out3;
      end else if (to_idle) begin
        sw1 <= '0;
        sw2 <= '0;
        sw3 <= '0;
      end
    end
  end

endmodule

// File: doc/pwm_rom_sequencer.md
# pwm_rom_sequencer

Reader side of the switching-state ROM in ModuladorHW. It drives the ROM's `en`/`addr` port at a programmable sample rate and steps through the stored table with wrap-around. It captures the three 4-bit switching words (`out1..out3`), compensating for the ROM's 1-cycle registered read latency, and presents them as aligned gate commands with a valid strobe and a period marker. The block sits between the ROM and the gate-drive/dead-time stage; it replaces the free-running address counter used in simulation.

## Interface
- `ADDR_W`, 16: ROM address width.
- `LAST_ADDR`, 2**ADDR_W-1: last table address; the read address wraps to 0 after it.
- `DIV_W`, 16: width of the sample-rate divider input.
- `clk`  in  1: single clock; ROM shares it.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: level-sampled; begins sequencing from address 0 when idle.
- `stop`  in  1: level-sampled; ends sequencing and forces outputs off.
- `div`  in  DIV_W: one ROM read every `div`+1 clocks.
- `rom_en`  out  1: ROM read enable (registered).
- `rom_addr`  out  ADDR_W: ROM address (registered).
- `rom_out1`, `rom_out2`, `rom_out3`  in  4 each: ROM data, valid 1 cycle after `rom_en`.
- `sw1`, `sw2`, `sw3`  out  4 each: registered switching words, phases 1–3.
- `sw_valid`  out  1: one-cycle pulse when `sw1..3` update.
- `period_tick`  out  1: pulses together with the `sw_valid` of the `LAST_ADDR` sample.
- `busy`  out  1: high in RUN and DRAIN.

## Operation
- FSM has three states: IDLE, RUN, DRAIN.
- IDLE → RUN when `start`=1 and `stop`=0.
  - Address counter loads 0.
  - Prescaler loads 0, so the first read issues on the first RUN cycle.
- RUN: the prescaler counts 0..`div`.
  - At count 0 the block asserts `rom_en` for 1 cycle with the current address, then increments the address.
  - If the issued address equals `LAST_ADDR`, the next address is 0.
  - `rom_en` is 0 at all other counts.
  - If `div`=0, `rom_en` stays high continuously.
- Read pipeline: a 2-stage valid shift register tracks each read.
  - The stage-1 flag is set with `rom_en`.
  - When the flag is set, the block captures `rom_out1..3` into `sw1..3` on the next edge and pulses `sw_valid`.
  - A last-address flag travels with the read and produces `period_tick`.
- `div` is sampled only when the prescaler reloads; a change takes effect on the next sample period.
- `start` while in RUN is ignored.
- `stop` while in RUN:
  - `rom_en` goes to 0 immediately; no new read issues.
  - If a read is outstanding, the FSM enters DRAIN. That read completes normally (`sw_valid`, and `period_tick` if applicable), then the FSM enters IDLE.
  - If no read is outstanding, the FSM goes directly to IDLE.
- Entering IDLE clears `sw1..3` to 0 (all switches off) and sets `rom_addr` to 0.
- Simultaneous `start` and `stop` in IDLE: `stop` wins and the FSM stays in IDLE.
- Address and prescaler arithmetic are unsigned, with no overflow beyond the `LAST_ADDR` wrap.

## Timing
- Reset values: state IDLE, `rom_en`=0, `rom_addr`=0, `sw1..3`=0, `sw_valid`=0, `period_tick`=0, `busy`=0, prescaler=0, pipeline flags=0.
- A reset asserted mid-operation takes effect at the next edge and discards any outstanding read; no `sw_valid` follows.
- `start` sampled at edge E0:
  - After E0: `busy`=1, `rom_en`=1, `rom_addr`=0.
  - After E2: `sw1..3` = ROM[0] and `sw_valid`=1.
  - Latency from `rom_en` to `sw_valid` is 2 cycles.
- Reads occur every `div`+1 cycles, so `sw_valid` pulses with the same spacing.
- `stop` sampled at edge Es:
  - `rom_en`=0 after Es.
  - `busy` falls no later than Es+2.
  - `sw1..3`=0 in the cycle after the final `sw_valid` cycle.
- Throughput is 1 sample per `div`+1 cycles.

## Test plan
- Reset values: assert `rst` for 3 cycles → all outputs 0; `busy`=0.
- Continuous read with wrap: `LAST_ADDR`=3, `div`=0, ROM model returns data = address; pulse `start` → `rom_addr` sequence 0,1,2,3,0,1…; `sw_valid` high every cycle from the 3rd cycle; `sw1`=3 coincides with `period_tick`=1.
- Divided rate: `div`=2 → `rom_en` high 1 cycle in every 3; `sw_valid` spaced 3 cycles apart; change `div` to 0 mid-period → new rate applies only after the current prescaler reload.
- Stop with an outstanding read: `div`=0, `stop` at the 5th RUN cycle → `rom_en` 0 next cycle; one more `sw_valid`; then `sw1..3`=0, `busy`=0 within 2 cycles.
- Start and stop together in IDLE → stays IDLE, `rom_en` never asserts. `start` during RUN → address sequence continues uninterrupted.
- Reset during RUN, with a read outstanding → no `sw_valid` afterward; all outputs at reset values; next `start` reads address 0.
